// File: rtl/case_cycler_pkg.sv
// Shared mode/direction encodings and Gray conversion helpers for case_state_cycler.
// Helpers work on GW_MAX-bit zero-extended values, so callers of any width <= GW_MAX can use them.
package case_cycler_pkg;

  localparam logic [1:0] MODE_INV  = 2'b00;
  localparam logic [1:0] MODE_BIN  = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int GW_MAX = 32;

  // Zero upper bits leave both conversions unchanged, which is what makes them width-agnostic.
  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
    logic [GW_MAX-1:0] b;
    b[GW_MAX-1] = g[GW_MAX-1];
    for (int i = GW_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/case_state_cycler_gray_step.sv
// Combinational single Gray-code step (up or down) with wrap detection on the decoded value.
module gray_step
  import case_cycler_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] gray_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] bin_cur;
  logic [WIDTH-1:0] bin_nxt;

  always_comb begin
    bin_cur = WIDTH'(gray2bin(GW_MAX'(gray_i)));
    if (dir_i == DIR_DOWN) begin
      bin_nxt = bin_cur - WIDTH'(1);
      wrap_o  = (bin_cur == '0);
    end else begin
      bin_nxt = bin_cur + WIDTH'(1);
      wrap_o  = (bin_cur == '1);
    end
    gray_o = WIDTH'(bin2gray(GW_MAX'(bin_nxt)));
  end

endmodule

// File: rtl/case_state_cycler.sv
// Registered WIDTH-bit state cycler: invert, binary count, Gray step or hold, selected by mode.
// Priority rst > load > en; all outputs are registered (latency 1).
module case_state_cycler
  import case_cycler_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             wrap,
  output logic [CNT_W-1:0] step_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] gray_nxt;
  logic             gray_wrap;

  gray_step #(.WIDTH(WIDTH)) u_gray_step (
    .gray_i (state_q),
    .dir_i  (dir),
    .gray_o (gray_nxt),
    .wrap_o (gray_wrap)
  );

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = load_val;
      cnt_d   = '0;
    end else if (en) begin
      case (mode)
        MODE_INV: begin
          state_d = ~state_q;
          wrap_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        MODE_BIN: begin
          if (dir == DIR_DOWN) begin
            state_d = state_q - WIDTH'(1);
            wrap_d  = (state_q == '0);
          end else begin
            state_d = state_q + WIDTH'(1);
            wrap_d  = (state_q == '1);
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        MODE_GRAY: begin
          state_d = gray_nxt;
          wrap_d  = gray_wrap;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = state_q;
          wrap_d  = 1'b0;
          cnt_d   = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out = state_q;
  assign wrap     = wrap_q;
  assign step_cnt = cnt_q;

endmodule
